// File: rtl/tensor_core_sequencer_if.sv
// Signal bundle between the host/issue logic, the tensor core register file,
// the MMA unit and tensor_core_sequencer.
interface tensor_core_sequencer_if;
    logic         cmd_valid_in;
    logic         cmd_ready_out;
    logic         operand_valid_in;
    logic [7:0]   operand_data_in;
    logic         operand_ready_out;
    logic         trf_write_enable_out;
    logic [4:0]   trf_write_address_out;
    logic [7:0]   trf_write_data_out;
    logic         mma_start_out;
    logic         mma_done_in;
    logic [127:0] tensor_core_result_in;
    logic         result_valid_out;
    logic [7:0]   result_data_out;
    logic         result_last_out;
    logic         result_ready_in;
    logic         busy_out;
    logic         timeout_error_out;

    modport master (
        output cmd_valid_in, operand_valid_in, operand_data_in, mma_done_in,
               tensor_core_result_in, result_ready_in,
        input  cmd_ready_out, operand_ready_out, trf_write_enable_out,
               trf_write_address_out, trf_write_data_out, mma_start_out,
               result_valid_out, result_data_out, result_last_out, busy_out,
               timeout_error_out
    );

    modport slave (
        input  cmd_valid_in, operand_valid_in, operand_data_in, mma_done_in,
               tensor_core_result_in, result_ready_in,
        output cmd_ready_out, operand_ready_out, trf_write_enable_out,
               trf_write_address_out, trf_write_data_out, mma_start_out,
               result_valid_out, result_data_out, result_last_out, busy_out,
               timeout_error_out
    );
endinterface

// File: rtl/tensor_core_sequencer.sv
// Runs one 4x4 MMA job: loads 32 operand bytes into the register file, fires
// the MMA, waits for done with a timeout and drains the snapshotted result.
module tensor_core_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                    clock_in,
    input  logic                    reset_in,
    tensor_core_sequencer_if.slave  bus
);
    localparam int unsigned TIMEOUT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FIRE,
        S_WAIT,
        S_DRAIN
    } state_e;

    state_e                   state_q;
    logic [4:0]               op_idx_q;
    logic [3:0]               res_idx_q;
    logic [TIMEOUT_WIDTH-1:0] tmo_q;
    logic [TIMEOUT_WIDTH-1:0] tmo_d;
    logic                     err_q;
    logic [127:0]             snap_q;
    logic                     done_ok;
    logic                     tmo_hit;

    assign tmo_d   = tmo_q + TIMEOUT_WIDTH'(1);
    // tmo_q is zero only in the first WAIT cycle, where done may be stale.
    assign done_ok = bus.mma_done_in && (tmo_q != '0);
    assign tmo_hit = (tmo_d == TIMEOUT_WIDTH'(TIMEOUT_CYCLES));

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q   <= S_IDLE;
            op_idx_q  <= '0;
            res_idx_q <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
            snap_q    <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid_in) begin
                        state_q  <= S_LOAD;
                        op_idx_q <= '0;
                        err_q    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (bus.operand_valid_in) begin
                        op_idx_q <= op_idx_q + 5'd1;
                        if (op_idx_q == 5'd31) begin
                            state_q <= S_FIRE;
                        end
                    end
                end
                S_FIRE: begin
                    tmo_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    tmo_q <= tmo_d;
                    if (done_ok) begin
                        snap_q    <= bus.tensor_core_result_in;
                        res_idx_q <= '0;
                        state_q   <= S_DRAIN;
                    end else if (tmo_hit) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (bus.result_ready_in) begin
                        res_idx_q <= res_idx_q + 4'd1;
                        if (res_idx_q == 4'd15) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready_out         = (state_q == S_IDLE);
    assign bus.operand_ready_out     = (state_q == S_LOAD);
    assign bus.trf_write_enable_out  = (state_q == S_LOAD) && bus.operand_valid_in;
    assign bus.trf_write_address_out = (state_q == S_LOAD) ? op_idx_q : '0;
    assign bus.trf_write_data_out    = (state_q == S_LOAD) ? bus.operand_data_in : '0;
    assign bus.mma_start_out         = (state_q == S_FIRE);
    assign bus.result_valid_out      = (state_q == S_DRAIN);
    assign bus.result_data_out       = (state_q == S_DRAIN) ? snap_q[{res_idx_q, 3'b000} +: 8] : '0;
    assign bus.result_last_out       = (state_q == S_DRAIN) && (res_idx_q == 4'd15);
    assign bus.busy_out              = (state_q != S_IDLE);
    assign bus.timeout_error_out     = err_q;

endmodule

// File: tb/tb_tensor_core_sequencer.sv
// Directed bench for tensor_core_sequencer: a cycle table for reset/handshake
// basics followed by complete jobs covering stalls, stale done, backpressure,
// timeout and mid-job reset.
module tb_tensor_core_sequencer;
    localparam int unsigned TMO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tensor_core_sequencer_if bus ();

    tensor_core_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock_in (clk),
        .reset_in (rst),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;
    logic       err_exp;
    logic [7:0] opa [16];
    logic [7:0] opb [16];
    logic [7:0] cexp [16];

    typedef struct {
        logic       rst;
        logic       cmd_v;
        logic       op_v;
        logic [7:0] op_d;
        logic       e_cmd_rdy;
        logic       e_op_rdy;
        logic       e_we;
        logic [4:0] e_addr;
        logic [7:0] e_wdata;
        logic       e_start;
        logic       e_rv;
        logic       e_busy;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " cmd_ready"}, bus.cmd_ready_out, 1);
        chk({tag, " op_ready"}, bus.operand_ready_out, 0);
        chk({tag, " we"}, bus.trf_write_enable_out, 0);
        chk({tag, " addr"}, bus.trf_write_address_out, 0);
        chk({tag, " wdata"}, bus.trf_write_data_out, 0);
        chk({tag, " start"}, bus.mma_start_out, 0);
        chk({tag, " rvalid"}, bus.result_valid_out, 0);
        chk({tag, " rdata"}, bus.result_data_out, 0);
        chk({tag, " rlast"}, bus.result_last_out, 0);
        chk({tag, " busy"}, bus.busy_out, 0);
    endtask

    // kind 0: A=I, B=1..16; kind 1: A=2I, B=1..16; kind 2: general matrices
    task automatic set_ops(input int kind);
        int acc;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                case (kind)
                    0: begin opa[4*i+j] = (i == j) ? 8'd1 : 8'd0; opb[4*i+j] = 8'(4*i+j+1); end
                    1: begin opa[4*i+j] = (i == j) ? 8'd2 : 8'd0; opb[4*i+j] = 8'(4*i+j+1); end
                    default: begin opa[4*i+j] = 8'(i+j+1); opb[4*i+j] = 8'(7*(4*i+j)+3); end
                endcase
            end
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = 0;
                for (int k = 0; k < 4; k++) acc += int'(opa[4*i+k]) * int'(opb[4*k+j]);
                cexp[4*i+j] = 8'(acc);
            end
        end
    endtask

    function automatic logic [127:0] pack_result();
        logic [127:0] r;
        r = '0;
        for (int e = 0; e < 16; e++) r[8*e +: 8] = cexp[e];
        return r;
    endfunction

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.cmd_valid_in     = 1'b0;
        bus.operand_valid_in = 1'b0;
        bus.mma_done_in      = 1'b0;
        bus.result_ready_in  = 1'b0;
        #1;
        chk_idle(tag);
        chk({tag, " err"}, bus.timeout_error_out, 0);
        err_exp = 1'b0;
        @(negedge clk);
    endtask

    // dly: first WAIT cycle (1-based) with done high, 0 = never
    task automatic run_job(input string tag, input bit stall, input bit stale, input int bp_at,
                           input int dly, input int rst_load, input int rst_drain, input bit lat_chk);
        int cyc, beat, w, k, hold;
        logic v, rdy;
        logic [7:0] d;
        bit got_done;

        bus.cmd_valid_in = 1'b1;
        bus.mma_done_in  = stale;
        #1;
        chk({tag, " accept cmd_ready"}, bus.cmd_ready_out, 1);
        chk({tag, " accept busy"}, bus.busy_out, 0);
        chk({tag, " accept err"}, bus.timeout_error_out, err_exp);
        @(negedge clk);
        bus.cmd_valid_in = 1'b0;
        err_exp = 1'b0;
        cyc = 1;
        beat = 0;

        while (beat < 32) begin
            v = stall ? (cyc % 2 == 1) : 1'b1;
            d = (beat < 16) ? opa[beat] : opb[beat-16];
            bus.operand_valid_in = v;
            bus.operand_data_in  = v ? d : 8'hEE;
            #1;
            chk($sformatf("%s load%0d op_ready", tag, beat), bus.operand_ready_out, 1);
            chk($sformatf("%s load%0d we", tag, beat), bus.trf_write_enable_out, v);
            chk($sformatf("%s load%0d addr", tag, beat), bus.trf_write_address_out, beat);
            chk($sformatf("%s load%0d wdata", tag, beat), bus.trf_write_data_out, v ? d : 8'hEE);
            chk($sformatf("%s load%0d start", tag, beat), bus.mma_start_out, 0);
            if (cyc == 1) chk({tag, " load err cleared"}, bus.timeout_error_out, 0);
            if (v && beat == rst_load) begin
                do_reset({tag, " reset in load"});
                return;
            end
            @(negedge clk);
            if (v) beat++;
            cyc++;
        end

        bus.operand_valid_in = 1'b0;
        #1;
        chk({tag, " fire start"}, bus.mma_start_out, 1);
        chk({tag, " fire we"}, bus.trf_write_enable_out, 0);
        chk({tag, " fire op_ready"}, bus.operand_ready_out, 0);
        chk({tag, " fire busy"}, bus.busy_out, 1);
        @(negedge clk);
        cyc++;

        got_done = 1'b0;
        for (w = 1; w <= int'(TMO); w++) begin
            if (!stale) bus.mma_done_in = (dly > 0) && (w >= dly);
            // first WAIT cycle shows a decoy result so an early capture is visible
            bus.tensor_core_result_in = (w == 1) ? ~pack_result() : pack_result();
            #1;
            chk($sformatf("%s wait%0d start", tag, w), bus.mma_start_out, 0);
            chk($sformatf("%s wait%0d rvalid", tag, w), bus.result_valid_out, 0);
            chk($sformatf("%s wait%0d busy", tag, w), bus.busy_out, 1);
            chk($sformatf("%s wait%0d cmd_ready", tag, w), bus.cmd_ready_out, 0);
            @(negedge clk);
            cyc++;
            if (bus.mma_done_in && w >= 2) begin
                got_done = 1'b1;
                break;
            end
        end
        bus.mma_done_in = 1'b0;

        if (!got_done) begin
            err_exp = 1'b1;
            for (int i = 0; i < 3; i++) begin
                #1;
                chk($sformatf("%s timeout%0d err", tag, i), bus.timeout_error_out, 1);
                chk($sformatf("%s timeout%0d rvalid", tag, i), bus.result_valid_out, 0);
                chk($sformatf("%s timeout%0d busy", tag, i), bus.busy_out, 0);
                chk($sformatf("%s timeout%0d cmd_ready", tag, i), bus.cmd_ready_out, 1);
                @(negedge clk);
            end
            return;
        end

        bus.tensor_core_result_in = {4{32'h5A5A_C3C3}};
        k = 0;
        hold = 0;
        while (k < 16) begin
            rdy = !(k == bp_at && hold < 5);
            bus.result_ready_in = rdy;
            if (!rdy) bus.tensor_core_result_in = {$urandom, $urandom, $urandom, $urandom};
            #1;
            if (k == 0 && hold == 0 && lat_chk) chk({tag, " first result cycle"}, cyc, 36);
            chk($sformatf("%s drain%0d rvalid", tag, k), bus.result_valid_out, 1);
            chk($sformatf("%s drain%0d rdata", tag, k), bus.result_data_out, cexp[k]);
            chk($sformatf("%s drain%0d rlast", tag, k), bus.result_last_out, (k == 15));
            chk($sformatf("%s drain%0d busy", tag, k), bus.busy_out, 1);
            if (rdy && k == rst_drain) begin
                do_reset({tag, " reset in drain"});
                return;
            end
            @(negedge clk);
            cyc++;
            if (rdy) k++;
            else hold++;
        end
        bus.result_ready_in = 1'b0;
        #1;
        chk_idle({tag, " post"});
        chk({tag, " post err"}, bus.timeout_error_out, 0);
        @(negedge clk);
    endtask

    vec_t vt [8];

    initial begin
        rst = 1'b1;
        bus.cmd_valid_in          = 1'b0;
        bus.operand_valid_in      = 1'b0;
        bus.operand_data_in       = 8'h00;
        bus.mma_done_in           = 1'b0;
        bus.tensor_core_result_in = '0;
        bus.result_ready_in       = 1'b0;
        err_exp = 1'b0;
        @(negedge clk);
        @(negedge clk);

        //        rst   cmd   opv   opd     crdy  ordy  we    addr  wdata  start rv    busy
        vt[0] = '{1'b1, 1'b0, 1'b0, 8'h00,  1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 8'h11,  1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b0, 1'b1, 8'hAA,  1'b0, 1'b1, 1'b1, 5'd0, 8'hAA, 1'b0, 1'b0, 1'b1};
        vt[3] = '{1'b0, 1'b0, 1'b0, 8'h55,  1'b0, 1'b1, 1'b0, 5'd1, 8'h55, 1'b0, 1'b0, 1'b1};
        vt[4] = '{1'b0, 1'b1, 1'b1, 8'h5A,  1'b0, 1'b1, 1'b1, 5'd1, 8'h5A, 1'b0, 1'b0, 1'b1};
        vt[5] = '{1'b1, 1'b0, 1'b1, 8'hC3,  1'b0, 1'b1, 1'b1, 5'd2, 8'hC3, 1'b0, 1'b0, 1'b1};
        vt[6] = '{1'b0, 1'b0, 1'b1, 8'h77,  1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[7] = '{1'b0, 1'b0, 1'b0, 8'h00,  1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 8; i++) begin
            rst                  = vt[i].rst;
            bus.cmd_valid_in     = vt[i].cmd_v;
            bus.operand_valid_in = vt[i].op_v;
            bus.operand_data_in  = vt[i].op_d;
            #1;
            chk($sformatf("vec%0d cmd_ready", i), bus.cmd_ready_out, vt[i].e_cmd_rdy);
            chk($sformatf("vec%0d op_ready", i), bus.operand_ready_out, vt[i].e_op_rdy);
            chk($sformatf("vec%0d we", i), bus.trf_write_enable_out, vt[i].e_we);
            chk($sformatf("vec%0d addr", i), bus.trf_write_address_out, vt[i].e_addr);
            chk($sformatf("vec%0d wdata", i), bus.trf_write_data_out, vt[i].e_wdata);
            chk($sformatf("vec%0d start", i), bus.mma_start_out, vt[i].e_start);
            chk($sformatf("vec%0d rvalid", i), bus.result_valid_out, vt[i].e_rv);
            chk($sformatf("vec%0d busy", i), bus.busy_out, vt[i].e_busy);
            chk($sformatf("vec%0d err", i), bus.timeout_error_out, 0);
            @(negedge clk);
        end
        rst = 1'b0;
        bus.cmd_valid_in     = 1'b0;
        bus.operand_valid_in = 1'b0;

        //           tag       stall stale bp  dly rstL rstD lat
        set_ops(0); run_job("nominal", 0, 0, -1, 3, -1, -1, 0);
        set_ops(1); run_job("latency", 0, 0, -1, 1, -1, -1, 1);
        set_ops(2); run_job("stall",   1, 0, -1, 3, -1, -1, 0);
        set_ops(0); run_job("stale",   0, 1, -1, 1, -1, -1, 1);
        set_ops(2); run_job("bp",      0, 0,  7, 2, -1, -1, 0);
        run_job("timeout", 0, 0, -1, 0, -1, -1, 0);
        set_ops(1); run_job("clear",   0, 0, -1, 3, -1, -1, 0);
        run_job("rstload", 0, 0, -1, 3, 10, -1, 0);
        set_ops(0); run_job("fresh1",  0, 0, -1, 2, -1, -1, 0);
        set_ops(2); run_job("rstdrain", 0, 0, -1, 2, -1, 5, 0);
        run_job("fresh2",  0, 0, -1, 4, -1, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
